// File: rtl/hazard_controller_if.sv
// hazard_controller_if: ID-stage decode, resolution and pipeline-control signals of the hazard controller.
interface hazard_controller_if;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_is_load;
  logic       id_mem_access;
  logic       ex_branch_taken;
  logic       dm_ready;
  logic       stall_if;
  logic       stall_id;
  logic       stall_ex;
  logic       stall_mem;
  logic       flush_id;
  logic       flush_ex;
  logic [1:0] forward_a;
  logic [1:0] forward_b;
  logic       ex_valid;
  logic       mem_valid;
  logic       wb_valid;
  logic [7:0] mem_wait_cycles;
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, id_is_load,
           id_mem_access, ex_branch_taken, dm_ready,
    input  stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, forward_a, forward_b,
           ex_valid, mem_valid, wb_valid, mem_wait_cycles
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, id_is_load,
           id_mem_access, ex_branch_taken, dm_ready,
    output stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, forward_a, forward_b,
           ex_valid, mem_valid, wb_valid, mem_wait_cycles
  );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush/forward control for a 5-stage pipeline with a waiting data memory.
module hazard_controller (
  input logic clk,
  input logic rst,
  hazard_controller_if.slave bus
);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       reg_write;
    logic       is_load;
    logic       mem_access;
  } ex_t;
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       is_load;
    logic       mem_access;
  } mem_t;
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
  } wb_t;
  ex_t    ex_q, ex_d;
  mem_t   mem_q, mem_d;
  wb_t    wb_q, wb_d;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic freeze, load_use, branch, flush_ex;
  // Loads are excluded from MEM forwarding: their data only exists once they reach WB.
  function automatic logic [1:0] fwd(input logic [4:0] rs);
    return !ex_q.valid ? 2'b00
         : (mem_q.valid && mem_q.reg_write && !mem_q.is_load && mem_q.rd != 5'd0 && mem_q.rd == rs) ? 2'b10
         : (wb_q.valid && wb_q.reg_write && wb_q.rd != 5'd0 && wb_q.rd == rs) ? 2'b01
         : 2'b00;
  endfunction
  always_comb begin
    freeze   = !rst && mem_q.valid && mem_q.mem_access && !bus.dm_ready;
    load_use = !rst && bus.id_valid && ex_q.valid && ex_q.is_load && ex_q.rd != 5'd0 &&
               ((bus.id_use_rs1 && bus.id_rs1 == ex_q.rd) || (bus.id_use_rs2 && bus.id_rs2 == ex_q.rd));
    branch   = !rst && !freeze && bus.ex_branch_taken;
    flush_ex = branch || (!freeze && load_use);
  end
  assign bus.stall_if        = freeze || (!branch && load_use);
  assign bus.stall_id        = freeze || (!branch && load_use);
  assign bus.stall_ex        = freeze;
  assign bus.stall_mem       = freeze;
  assign bus.flush_id        = branch;
  assign bus.flush_ex        = flush_ex;
  assign bus.forward_a       = fwd(ex_q.rs1);
  assign bus.forward_b       = fwd(ex_q.rs2);
  assign bus.ex_valid        = ex_q.valid;
  assign bus.mem_valid       = mem_q.valid;
  assign bus.wb_valid        = wb_q.valid;
  assign bus.mem_wait_cycles = cnt_q;
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (freeze) begin
      wb_d.valid = 1'b0;
    end else begin
      wb_d  = '{mem_q.valid, mem_q.rd, mem_q.reg_write};
      mem_d = '{ex_q.valid, ex_q.rd, ex_q.reg_write, ex_q.is_load, ex_q.mem_access};
      ex_d  = '{bus.id_valid && !flush_ex, bus.id_rs1, bus.id_rs2, bus.id_rd,
                bus.id_reg_write, bus.id_is_load, bus.id_mem_access};
    end
    state_d = freeze ? MEM_WAIT : RUN;
    cnt_d   = !freeze ? cnt_q
            : state_q == RUN ? 8'd1
            : cnt_q == 8'hff ? cnt_q
            : cnt_q + 8'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
